spiking_pe: RTL and testbench
=============================

Name: spiking_pe

Overview:
- Single processing element of a 2-D systolic array for spiking (binary-activation) neural networks.
- A 1-bit spike enters on the row (left) and a signed 16-bit weight/operand enters on the column (top).
- The PE adds the column operand into a local signed accumulator whenever the row spike is 1; multiplication is not needed because activations are binary.
- Both inputs are forwarded, registered, to the right and bottom neighbours.

Parameters:
- DATA_W, 16, width of the column operand, the forwarded column and the accumulator/out_data (signed two's complement).

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- in_row  input  1  spike from left neighbour (1 = spike)
- in_col  input  DATA_W  signed operand from top neighbour
- out_data  output  DATA_W  signed accumulator value (registered)
- out_row  output  1  in_row delayed one cycle, to right neighbour
- out_col  output  DATA_W  in_col delayed one cycle, to bottom neighbour

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high; rst has priority over every other action.
- Reset values: out_data=0, out_row=0, out_col=0.
- Forwarding: out_row <= in_row and out_col <= in_col every non-reset cycle. Latency is exactly 1 cycle, with no gating and no enable.
- Accumulate:
  - When in_row==1, out_data <= out_data + in_col, evaluated on the operands present in the same cycle.
  - When in_row==0, out_data holds.
  - Result is visible the cycle after the spike.
- Arithmetic:
  - Signed DATA_W addition.
  - Overflow handling depends on SPIKING_PE_SAT_EN (below).
  - Negative in_col values decrement the accumulator.
- Reset mid-operation: an accumulation in the reset cycle is discarded, and all outputs read 0 the following cycle.
- No combinational path from any input to any output.
- X/undefined on in_row before the first reset is irrelevant; outputs are defined from the first reset edge.

Optional Feature:
- Macro SPIKING_PE_SAT_EN.
- Defined: the accumulator add saturates.
  - Positive overflow clamps to +(2^(DATA_W-1))-1, i.e. 32767.
  - Negative overflow clamps to -(2^(DATA_W-1)), i.e. -32768.
  - Overflow is detected from the operand signs vs the result sign.
- Not defined: plain two's-complement wrap-around (e.g. 32767 + 1 = -32768).
- Forwarding paths are unaffected either way.

Decomposition:
- Package spiking_pe_pkg holds:
  - constant DATA_W default 16;
  - derived constants SAT_MAX and SAT_MIN;
  - a signed data typedef data_t.
- One natural sub-module: spike_sat_adder. It is a combinational signed add of acc + operand with the saturate-or-wrap selection controlled by SPIKING_PE_SAT_EN. The PE top instantiates it and holds the three registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles while in_row=1 and in_col=50 -> out_data=0, out_row=0, out_col=0 in each cycle; release rst -> the first accumulate is visible one cycle later with out_data=50.
- Forwarding: drive in_row=1,0,1 and in_col=5,-7,100 on consecutive cycles -> out_row=1,0,1 and out_col=5,-7,100, each one cycle later.
- Gated accumulate: from 0, apply (spike,col) = (1,10), (0,99), (1,-3), (1,20) -> out_data sequence 10, 10, 7, 27.
- Overflow, SPIKING_PE_SAT_EN defined: preload to 32760 by accumulation, then spike with col=100 -> out_data=32767. Then drive -32768 spikes repeatedly -> out_data clamps at -32768.
- Overflow, macro undefined: 32760 + 100 -> out_data = -32676 (wrap).
- Random soak: random in_col in -126..126 and random spike bit for 10k cycles, compared against a reference model -> exact match each cycle, including the 1-cycle forward delays.

Source files
------------

// File: rtl/spiking_pe_pkg.sv
// spiking_pe_pkg: shared width, saturation bounds and signed data type for the spiking PE
package spiking_pe_pkg;
  localparam int DATA_W = 16;
  typedef logic signed [DATA_W-1:0] data_t;
  localparam data_t SAT_MAX = data_t'({1'b0, {(DATA_W-1){1'b1}}});
  localparam data_t SAT_MIN = data_t'({1'b1, {(DATA_W-1){1'b0}}});
endpackage

// File: rtl/spike_sat_adder.sv
// spike_sat_adder: combinational signed acc+op (ports acc, op -> sum); clamps on overflow when SPIKING_PE_SAT_EN is defined, else wraps
module spike_sat_adder #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] acc,
  input  logic signed [DATA_W-1:0] op,
  output logic signed [DATA_W-1:0] sum
);
  logic signed [DATA_W-1:0] raw;
  assign raw = acc + op;
`ifdef SPIKING_PE_SAT_EN
  logic ovf;
  assign ovf = (acc[DATA_W-1] == op[DATA_W-1]) && (raw[DATA_W-1] != acc[DATA_W-1]);
  assign sum = ovf ? (acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}}) : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/spiking_pe.sv
// spiking_pe: systolic spiking PE (clk, rst, in_row spike, in_col operand -> out_data accumulator, out_row/out_col forwarded one cycle); saturating add with SPIKING_PE_SAT_EN
module spiking_pe
  import spiking_pe_pkg::*;
#(
  parameter int DATA_W = spiking_pe_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_row,
  input  logic [DATA_W-1:0] in_col,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row,
  output logic [DATA_W-1:0] out_col
);
  logic signed [DATA_W-1:0] sum;
  spike_sat_adder #(.DATA_W(DATA_W)) u_add (
    .acc(out_data),
    .op (in_col),
    .sum(sum)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_row  <= 1'b0;
      out_col  <= '0;
    end else begin
      out_row  <= in_row;
      out_col  <= in_col;
      out_data <= in_row ? sum : out_data;
    end
  end
endmodule

// File: tb/tb_spiking_pe.sv
// tb_spiking_pe: directed and random checks of spiking_pe against an integer reference model
module tb_spiking_pe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_row = 1'b0;
  logic [15:0] in_col = '0;
  logic [15:0] out_data, out_col;
  logic out_row;
  int errs = 0;
  int checks = 0;
  int m_acc = 0, m_row = 0, m_col = 0;
  spiking_pe dut (
    .clk(clk), .rst(rst), .in_row(in_row), .in_col(in_col),
    .out_data(out_data), .out_row(out_row), .out_col(out_col)
  );
  always #5 clk = ~clk;
  function automatic int add_ref(input int a, input int b);
    int s;
    logic signed [15:0] t;
    s = a + b;
`ifdef SPIKING_PE_SAT_EN
    return s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
`else
    t = s[15:0];
    return int'(t);
`endif
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input int c);
    logic signed [15:0] cs;
    rst = r;
    in_row = s;
    in_col = c[15:0];
    cs = c[15:0];
    @(posedge clk);
    #1;
    if (r) begin
      m_acc = 0; m_row = 0; m_col = 0;
    end else begin
      if (s) m_acc = add_ref(m_acc, int'(cs));
      m_row = int'(s);
      m_col = int'(cs);
    end
    chk("out_data", int'($signed(out_data)), m_acc);
    chk("out_row", int'(out_row), m_row);
    chk("out_col", int'($signed(out_col)), m_col);
  endtask
  initial begin
    step(1, 1, 50);
    chk("reset_data_c1", int'($signed(out_data)), 0);
    step(1, 1, 50);
    chk("reset_data_c2", int'($signed(out_data)), 0);
    step(0, 1, 50);
    chk("first_acc", int'($signed(out_data)), 50);
    step(0, 1, 5);
    chk("fwd_col0", int'($signed(out_col)), 5);
    step(0, 0, -7);
    chk("fwd_row1", int'(out_row), 0);
    chk("fwd_col1", int'($signed(out_col)), -7);
    step(0, 1, 100);
    chk("fwd_col2", int'($signed(out_col)), 100);
    step(1, 0, 0);
    step(0, 1, 10);
    chk("gate_a", int'($signed(out_data)), 10);
    step(0, 0, 99);
    chk("gate_b", int'($signed(out_data)), 10);
    step(0, 1, -3);
    chk("gate_c", int'($signed(out_data)), 7);
    step(0, 1, 20);
    chk("gate_d", int'($signed(out_data)), 27);
    step(1, 1, 1234);
    chk("reset_mid", int'($signed(out_data)), 0);
    for (int i = 0; i < 327; i++) step(0, 1, 100);
    step(0, 1, 60);
    chk("preload", int'($signed(out_data)), 32760);
    step(0, 1, 100);
`ifdef SPIKING_PE_SAT_EN
    chk("sat_pos", int'($signed(out_data)), 32767);
    for (int i = 0; i < 3; i++) step(0, 1, -32768);
    chk("sat_neg", int'($signed(out_data)), -32768);
`else
    chk("wrap_pos", int'($signed(out_data)), -32676);
    for (int i = 0; i < 3; i++) step(0, 1, -32768);
`endif
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 252)) - 126);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
